nmr_bstrm_arb_seq: RTL and testbench
====================================

# nmr_bstrm_arb_seq

Sequence controller for the NMR bitstream arbitrary-pulse datapath. It fetches a program of instruction words from an external synchronous RAM and presents them one at a time to the datapath's word inputs. It kicks the datapath with `dp_START`, then reloads the next word on every `dp_DONE` from a one-entry prefetch buffer, and stops at an end-of-sequence word, on abort or on prefetch underrun.

## Interface
- `DATA_WIDTH`, 20: datapath data width.
- `ADDR_WIDTH`, 8: program RAM address width.
- `CLK` in 1: system clock; all logic on rising edge.
- `RST` in 1: reset, synchronous and active-high.
- `START` in 1: sequence start request; a one-cycle pulse is sufficient.
- `ABORT` in 1: terminates the running sequence.
- `ADDR_BASE` in ADDR_WIDTH: first program address, sampled when START is accepted.
- `BUSY` out 1: sequence in progress.
- `DONE` out 1: one-cycle pulse when the sequence ends.
- `UNDERRUN` out 1: sticky flag; prefetch was not ready at `dp_DONE`.
- `mem_rd` out 1: RAM read strobe.
- `mem_addr` out ADDR_WIDTH: RAM read address.
- `mem_q` in DATA_WIDTH+2: RAM read data. Bits [DATA_WIDTH+1:DATA_WIDTH] are the mode; bits [DATA_WIDTH-1:0] are data.
- `dp_START` out 1: datapath start pulse.
- `dp_DONE` in 1: datapath has consumed the current word.
- `data` out DATA_WIDTH: word data/length to the datapath.
- `pattern_mode`, `all_1_mode`, `all_0_mode`, `end_of_sequence` out 1 each: one-hot mode to the datapath.

## Operation
- **Mode decode** of `mem_q[DATA_WIDTH+1:DATA_WIDTH]`:
  - 00 → `all_0_mode`
  - 01 → `all_1_mode`
  - 10 → `pattern_mode`
  - 11 → `end_of_sequence`, with `data` forced to 0.
- **EOS word:** `end_of_sequence`=1, all other mode bits 0, `data`=0.
- **RAM:** read latency 1. A read with `mem_rd`=1 in cycle n gives `mem_q` valid in cycle n+1.
- **States:** IDLE, RD_FIRST, LD_FIRST, KICK, RUN, FINISH.
- **IDLE:** START accepted when ABORT=0. On acceptance: `mem_addr`←`ADDR_BASE`, `mem_rd`←1, `BUSY`←1, `UNDERRUN`←0, go to RD_FIRST. `dp_DONE` is ignored.
- **RD_FIRST:** `mem_rd`←0; go to LD_FIRST.
- **LD_FIRST:** word registers ← decode(`mem_q`).
  - If the word is EOS, go to FINISH.
  - Otherwise `mem_addr`←`mem_addr`+1, `mem_rd`←1, go to KICK.
- **KICK:** `dp_START` is high this cycle only. Go to RUN.
- **Prefetch buffer:** in the cycle after any issued read, `pf`←`mem_q` and `pf_valid`←1. This happens in the cycle after LD_FIRST and in the cycle after each RUN reload.
- **RUN, on `dp_DONE`:**
  - If `pf_valid`=1: word registers ← `pf`, `pf_valid`←0. If `pf` is EOS, go to FINISH. Otherwise `mem_addr`+1 and issue a read.
  - If `pf_valid`=0: word registers ← EOS, `UNDERRUN`←1, go to FINISH. Any in-flight read is discarded.
- **FINISH:** `DONE`=1 for one cycle, `BUSY`←0, go to IDLE. The word registers hold their value until the next sequence loads.
- **ABORT** in any state other than IDLE: word registers ← EOS, `mem_rd`←0, `pf_valid`←0, go to FINISH.
- **Priorities:**
  - ABORT beats `dp_DONE`.
  - ABORT beats START in IDLE; the START is not accepted.
  - START while `BUSY`=1 is ignored.
- **Address arithmetic:** modulo 2^ADDR_WIDTH; address all-ones increments to 0.
- **Reset:** RST returns to IDLE from any state, mid-sequence included. No DONE is generated.

## Timing
- **All outputs are registered.** After RST, every output is 0, `pf_valid`=0 and `mem_addr`=0.
- **START sampled in cycle 0:**
  - `BUSY`=1 and `mem_rd`=1 (`ADDR_BASE`) in cycle 1.
  - First word on the datapath outputs in cycle 3, together with `mem_rd`=1 (`ADDR_BASE`+1) and `dp_START`=1.
  - `pf` valid from cycle 5.
- **First word is EOS:** EOS outputs in cycle 3, `DONE` in cycle 3, `BUSY`=0 in cycle 4. No `dp_START`.
- **`dp_DONE` in cycle d:** new word visible in d+1; read issued in d+1; `pf` valid from d+3.
  - Minimum legal spacing between `dp_DONE` pulses is 3 cycles; closer spacing produces underrun.
  - The first `dp_DONE` must not come before cycle 5.
- **End of sequence:** `dp_DONE` in cycle d that loads EOS, underruns, or coincides with ABORT gives `DONE` in d+1 and `BUSY`=0 in d+2. ABORT in cycle a gives EOS outputs and `DONE` in a+1.

## Test plan
- **Normal run:**
  - Stimulus: RAM[0..3] = {01,10}, {10,0xA3B8E}, {00,7}, {11,x}; ADDR_BASE=0; START; `dp_DONE` 6 cycles after each new word.
  - Response: words presented in order with correct one-hot; `dp_START` in cycle 3 only; `DONE` once; `BUSY` low afterwards; `UNDERRUN`=0.
- **First word EOS:**
  - Stimulus: RAM[5]={11,x}; ADDR_BASE=5.
  - Response: no `dp_START`; `DONE` in cycle 3; `mem_rd` asserted exactly once.
- **Underrun:**
  - Stimulus: `dp_DONE` 1 cycle after the second word appears.
  - Response: EOS outputs, `UNDERRUN`=1, `DONE` next cycle. The next accepted START clears `UNDERRUN`.
- **Abort:**
  - Stimulus: ABORT and `dp_DONE` in the same RUN cycle.
  - Response: EOS outputs, no reload from `pf`, `DONE` in the following cycle. START+ABORT in IDLE → `BUSY` stays 0.
- **Wrap:**
  - Stimulus: ADDR_WIDTH=8, ADDR_BASE=0xFE, four-word program.
  - Response: `mem_addr` sequence FE, FF, 00, 01.
- **Reset mid-run:**
  - Stimulus: RST in RUN; START asserted while `BUSY`=1.
  - Response: after RST all outputs are 0 with no `DONE`; the START while busy is ignored.

Source files
------------

// File: rtl/nmr_bstrm_arb_seq.sv
// Sequence controller for the NMR bitstream arbitrary-pulse datapath.
// Streams program words from a sync RAM through a one-entry prefetch.
module nmr_bstrm_arb_seq #(
  parameter int DATA_WIDTH = 20,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  ABORT,
  input  logic [ADDR_WIDTH-1:0] ADDR_BASE,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  UNDERRUN,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH+1:0] mem_q,
  output logic                  dp_START,
  input  logic                  dp_DONE,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  pattern_mode,
  output logic                  all_1_mode,
  output logic                  all_0_mode,
  output logic                  end_of_sequence
);

  localparam int WW = DATA_WIDTH + 4;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_FIRST = 3'd1;
  localparam logic [2:0] S_LD_FIRST = 3'd2;
  localparam logic [2:0] S_KICK     = 3'd3;
  localparam logic [2:0] S_RUN      = 3'd4;
  localparam logic [2:0] S_FINISH   = 3'd5;

  localparam logic [WW-1:0] EOS_W =
    {4'b1000, {DATA_WIDTH{1'b0}}};

  // word register layout: {eos, pattern, all_1, all_0, data}
  function automatic logic [WW-1:0] dec(
    input logic [DATA_WIDTH+1:0] q
  );
    logic [DATA_WIDTH-1:0] d;
    d = q[DATA_WIDTH-1:0];
    unique case (q[DATA_WIDTH+1:DATA_WIDTH])
      2'b00:   dec = {4'b0001, d};
      2'b01:   dec = {4'b0010, d};
      2'b10:   dec = {4'b0100, d};
      default: dec = EOS_W;
    endcase
  endfunction

  logic [2:0]            state;
  logic [WW-1:0]         word;
  logic [DATA_WIDTH+1:0] pf;
  logic                  pf_valid;
  logic                  pf_pend;
  logic                  abort_go;
  logic                  pf_eos;
  logic                  q_eos;

  assign {end_of_sequence, pattern_mode,
          all_1_mode, all_0_mode, data} = word;

  // abort only matters while a sequence is active and not ending
  assign abort_go = ABORT
                  && (state != S_IDLE)
                  && (state != S_FINISH);

  assign pf_eos = &pf[DATA_WIDTH+1:DATA_WIDTH];
  assign q_eos  = &mem_q[DATA_WIDTH+1:DATA_WIDTH];

  // sequencer, fetch and prefetch control
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      word     <= '0;
      pf       <= '0;
      pf_valid <= 1'b0;
      pf_pend  <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      UNDERRUN <= 1'b0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      dp_START <= 1'b0;
    end else begin
      DONE     <= 1'b0;
      dp_START <= 1'b0;
      if (abort_go) begin
        word     <= EOS_W;
        mem_rd   <= 1'b0;
        pf_valid <= 1'b0;
        pf_pend  <= 1'b0;
        DONE     <= 1'b1;
        state    <= S_FINISH;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (START && !ABORT) begin
              mem_addr <= ADDR_BASE;
              mem_rd   <= 1'b1;
              BUSY     <= 1'b1;
              UNDERRUN <= 1'b0;
              pf_valid <= 1'b0;
              pf_pend  <= 1'b0;
              state    <= S_RD_FIRST;
            end
          end
          S_RD_FIRST: begin
            mem_rd <= 1'b0;
            state  <= S_LD_FIRST;
          end
          S_LD_FIRST: begin
            word <= dec(mem_q);
            if (q_eos) begin
              DONE  <= 1'b1;
              state <= S_FINISH;
            end else begin
              mem_addr <= mem_addr + 1'b1;
              mem_rd   <= 1'b1;
              dp_START <= 1'b1;
              state    <= S_KICK;
            end
          end
          S_KICK: begin
            mem_rd  <= 1'b0;
            pf_pend <= 1'b1;
            state   <= S_RUN;
          end
          S_RUN: begin
            if (mem_rd) begin
              mem_rd  <= 1'b0;
              pf_pend <= 1'b1;
            end
            if (pf_pend) begin
              pf       <= mem_q;
              pf_valid <= 1'b1;
              pf_pend  <= 1'b0;
            end
            if (dp_DONE) begin
              if (pf_valid) begin
                word     <= dec(pf);
                pf_valid <= 1'b0;
                if (pf_eos) begin
                  DONE  <= 1'b1;
                  state <= S_FINISH;
                end else begin
                  mem_addr <= mem_addr + 1'b1;
                  mem_rd   <= 1'b1;
                end
              end else begin
                word     <= EOS_W;
                UNDERRUN <= 1'b1;
                mem_rd   <= 1'b0;
                pf_valid <= 1'b0;
                pf_pend  <= 1'b0;
                DONE     <= 1'b1;
                state    <= S_FINISH;
              end
            end
          end
          S_FINISH: begin
            BUSY  <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nmr_bstrm_arb_seq.sv
// Randomized bench for nmr_bstrm_arb_seq.
// Transaction-level reference model with a sync RAM model.
module tb_nmr_bstrm_arb_seq;

  localparam int DW = 20;
  localparam int AW = 8;
  localparam logic [23:0] EOSW = 24'h800000;

  logic          CLK = 1'b0;
  logic          RST;
  logic          START;
  logic          ABORT;
  logic [AW-1:0] ADDR_BASE;
  logic          BUSY;
  logic          DONE;
  logic          UNDERRUN;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW+1:0] mem_q;
  logic          dp_START;
  logic          dp_DONE;
  logic [DW-1:0] data;
  logic          pattern_mode;
  logic          all_1_mode;
  logic          all_0_mode;
  logic          end_of_sequence;

  logic [23:0]   outw;
  logic [36:0]   all_out;
  logic [DW+1:0] ram [256];

  int n_tests = 0;
  int n_fail  = 0;

  nmr_bstrm_arb_seq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT),
    .ADDR_BASE(ADDR_BASE), .BUSY(BUSY), .DONE(DONE),
    .UNDERRUN(UNDERRUN), .mem_rd(mem_rd),
    .mem_addr(mem_addr), .mem_q(mem_q),
    .dp_START(dp_START), .dp_DONE(dp_DONE), .data(data),
    .pattern_mode(pattern_mode), .all_1_mode(all_1_mode),
    .all_0_mode(all_0_mode),
    .end_of_sequence(end_of_sequence)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK)
    if (mem_rd) mem_q <= ram[mem_addr];

  assign outw = {end_of_sequence, pattern_mode,
                 all_1_mode, all_0_mode, data};
  assign all_out = {BUSY, DONE, UNDERRUN, mem_rd,
                    dp_START, mem_addr, outw};

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [23:0] ref_word(
    input logic [DW+1:0] q
  );
    int m;
    m = int'(q[DW+1:DW]);
    if (m == 3) return EOSW;
    return {4'(1 << m), q[DW-1:0]};
  endfunction

  function automatic logic [DW+1:0] prog(
    input logic [7:0] base, input int i
  );
    logic [7:0] a;
    a = base + 8'(i);
    return ram[a];
  endfunction

  task automatic load_prog(input logic [7:0] base,
                           input int len);
    logic [7:0] a;
    for (int i = 0; i < len; i++) begin
      a = base + 8'(i);
      ram[a] = {2'($urandom_range(2, 0)),
                20'($urandom)};
    end
    a = base + 8'(len);
    ram[a] = {2'b11, 20'($urandom)};
  endtask

  function automatic int pick_k(input int idx,
                                input int kfix,
                                input int under_at);
    if (idx == under_at) return 1;
    if (kfix > 0) return kfix;
    if (idx == 0) return int'($urandom_range(6, 2));
    return int'($urandom_range(6, 1));
  endfunction

  // one sequence, cycle 0 = the cycle START is sampled
  task automatic run_seq(input logic [7:0] base,
                         input int kfix,
                         input int under_at,
                         input int abort_at,
                         input bit mid_start);
    int w, idx, next_dd, n_dd;
    int done_c, kick_c, rd_c, under_c;
    logic [7:0] rd_a;
    logic [23:0] xw;
    bit dd, ab;
    w = -1; idx = 0; next_dd = -1; n_dd = 0;
    done_c = -1; kick_c = -1; under_c = -1;
    rd_c = 1; rd_a = base; xw = '0;
    START = 1'b1; ADDR_BASE = base;
    for (int c = 1; c < 400; c++) begin
      @(negedge CLK);
      START = mid_start && (c == 4);
      ADDR_BASE = base + 8'h40;
      dp_DONE = 1'b0; ABORT = 1'b0;
      check("busy", 64'(BUSY),
            64'(done_c < 0 || c <= done_c));
      check("done", 64'(DONE), 64'(c == done_c));
      check("kick", 64'(dp_START), 64'(c == kick_c));
      check("rd", 64'(mem_rd), 64'(c == rd_c));
      if (c == rd_c)
        check("addr", 64'(mem_addr), 64'(rd_a));
      check("under", 64'(UNDERRUN),
            64'(under_c >= 0 && c >= under_c));
      if (w > 0 && c >= w)
        check("word", 64'(outw), 64'(xw));
      if (done_c >= 0 && c > done_c) break;
      dd = (done_c < 0) && (c == next_dd);
      if (dd) n_dd++;
      ab = dd && (n_dd == abort_at);
      dp_DONE = dd; ABORT = ab;
      if (done_c >= 0) begin
      end else if (ab) begin
        w = c + 1; xw = EOSW; done_c = c + 1;
      end else if (c == 2) begin
        w = 3;
        xw = ref_word(prog(base, 0));
        if (xw[23]) done_c = 3;
        else begin
          kick_c = 3; rd_c = 3; rd_a = base + 8'd1;
          next_dd = 3 + pick_k(0, kfix, under_at);
        end
      end else if (dd) begin
        if (c < w + 2) begin
          w = c + 1; xw = EOSW;
          done_c = c + 1; under_c = c + 1;
        end else begin
          idx++;
          w = c + 1;
          xw = ref_word(prog(base, idx));
          if (xw[23]) done_c = c + 1;
          else begin
            rd_c = c + 1;
            rd_a = base + 8'(idx + 1);
            next_dd = w + pick_k(idx, kfix, under_at);
          end
        end
      end
    end
    if (done_c < 0) check("timeout", 64'd0, 64'd1);
    START = 1'b0; dp_DONE = 1'b0; ABORT = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = '0;
    RST = 1'b1; START = 1'b0; ABORT = 1'b0;
    dp_DONE = 1'b0; ADDR_BASE = '0;
    repeat (3) @(negedge CLK);
    check("rst_out", 64'(all_out), 64'd0);
    RST = 1'b0;
    @(negedge CLK);

    // fixed four-word program from address 0
    ram[0] = {2'b01, 20'd10};
    ram[1] = {2'b10, 20'hA3B8E};
    ram[2] = {2'b00, 20'd7};
    ram[3] = {2'b11, 20'hFFFFF};
    run_seq(8'h00, 6, -1, 0, 1'b1);

    // first word already end-of-sequence
    ram[5] = {2'b11, 20'h5A5A5};
    run_seq(8'h05, 0, -1, 0, 1'b0);

    // dp_DONE one cycle after the second word
    load_prog(8'h30, 4);
    run_seq(8'h30, 3, 1, 0, 1'b0);

    // START with ABORT in idle is refused
    START = 1'b1; ABORT = 1'b1;
    @(negedge CLK);
    START = 1'b0; ABORT = 1'b0;
    check("idle_ab_busy", 64'(BUSY), 64'd0);
    check("idle_ab_rd", 64'(mem_rd), 64'd0);
    check("under_sticky", 64'(UNDERRUN), 64'd1);
    @(negedge CLK);
    check("idle_ab_busy2", 64'(BUSY), 64'd0);

    // abort together with the second dp_DONE
    load_prog(8'h50, 5);
    run_seq(8'h50, 3, -1, 2, 1'b0);

    // address wrap FE, FF, 00, 01
    load_prog(8'hFE, 3);
    run_seq(8'hFE, 3, -1, 0, 1'b0);

    // reset in the middle of a run
    load_prog(8'h20, 6);
    START = 1'b1; ADDR_BASE = 8'h20;
    @(negedge CLK);
    START = 1'b0;
    repeat (3) @(negedge CLK);
    START = 1'b1; ADDR_BASE = 8'h90;
    @(negedge CLK);
    START = 1'b0;
    check("busy_ign", 64'(BUSY), 64'd1);
    check("addr_ign", 64'(mem_addr), 64'h21);
    check("rd_ign", 64'(mem_rd), 64'd0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("rst_mid", 64'(all_out), 64'd0);
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("rst_nodone", 64'({DONE, BUSY}), 64'd0);
    end

    // randomized programs and dp_DONE spacing
    for (int r = 0; r < 40; r++) begin
      logic [7:0] b;
      b = 8'($urandom);
      load_prog(b, int'($urandom_range(6, 0)));
      run_seq(b, 0, -1,
              int'($urandom_range(4, 0)),
              1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
